// File: rtl/video_pkg.sv
// +------------------------------------------------------------------+
// | video_pkg : shared 720p timing defaults, address width, types     |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package video_pkg;

  localparam int unsigned c_H_ACTIVE   = 1280;
  localparam int unsigned c_H_FP       = 110;
  localparam int unsigned c_H_SYNC     = 40;
  localparam int unsigned c_H_BP       = 220;
  localparam int unsigned c_H_TOTAL    = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

  localparam int unsigned c_V_ACTIVE   = 720;
  localparam int unsigned c_V_FP       = 5;
  localparam int unsigned c_V_SYNC     = 5;
  localparam int unsigned c_V_BP       = 20;
  localparam int unsigned c_V_TOTAL    = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

  localparam int unsigned c_FB_LATENCY = 2;
  localparam int unsigned c_FB_ADDR_W  = 20;
  localparam int unsigned c_ID_W       = 6;
  localparam int unsigned c_CH_W       = 8;

  // Colour IDs above this saturate to full intensity.
  localparam logic [c_ID_W-1:0] c_ID_SAT_LAST = 6'd23;
  localparam logic [c_CH_W-1:0] c_ID_STEP     = 8'd11;

  typedef logic [c_FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic fs;
    logic vs;
    logic hs;
    logic de;
  } ctl_t;

endpackage

`default_nettype wire

// File: rtl/palette_lut.sv
// +------------------------------------------------------------------+
// | palette_lut : colour-ID to RGB, registered, blanked when !en_i    |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

module palette_lut
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [c_ID_W-1:0] id_i,
  input  logic              mode_i,
  output logic [c_CH_W-1:0] red_o,
  output logic [c_CH_W-1:0] green_o,
  output logic [c_CH_W-1:0] blue_o
);

  logic [c_CH_W-1:0] inten;
  logic [c_CH_W-1:0] red_d, green_d, blue_d;
  logic [c_CH_W-1:0] red_q, green_q, blue_q;

  always_comb begin
    inten   = {2'b00, id_i} * c_ID_STEP;
    if (id_i > c_ID_SAT_LAST) begin
      inten = 8'd255;
    end
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (en_i) begin
      blue_d = inten;
      if (mode_i) begin
        red_d   = inten >> 1;
        green_d = inten - (inten >> 2);
      end else begin
        red_d   = inten;
        green_d = inten;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// +------------------------------------------------------------------+
// | fb_scanout : raster timing, framebuffer address walk, sync delay  |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

module fb_scanout
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = c_H_ACTIVE,
  parameter int unsigned H_FP       = c_H_FP,
  parameter int unsigned H_SYNC     = c_H_SYNC,
  parameter int unsigned H_BP       = c_H_BP,
  parameter int unsigned V_ACTIVE   = c_V_ACTIVE,
  parameter int unsigned V_FP       = c_V_FP,
  parameter int unsigned V_SYNC     = c_V_SYNC,
  parameter int unsigned V_BP       = c_V_BP,
  parameter int unsigned FB_LATENCY = c_FB_LATENCY
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   color_mode,
  output logic [c_FB_ADDR_W-1:0] fb_addr,
  input  logic [c_ID_W-1:0]      fb_data,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [c_CH_W-1:0]      red,
  output logic [c_CH_W-1:0]      green,
  output logic [c_CH_W-1:0]      blue,
  output logic                   frame_start
);

  localparam int unsigned c_H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned c_HW    = $clog2(c_H_LEN);
  localparam int unsigned c_VW    = $clog2(c_V_LEN);
  localparam int unsigned c_DEPTH = FB_LATENCY + 1;

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_LEN - 1);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_LEN - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_HW-1:0] h_cnt_q, h_cnt_d;
  logic [c_VW-1:0] v_cnt_q, v_cnt_d;
  fb_addr_t        addr_q, addr_d;
  logic            mode_q;
  ctl_t            ctl_raw;
  ctl_t            dly_q [c_DEPTH];
  logic            pal_en;

  always_comb begin
    ctl_raw.de = (h_cnt_q < c_H_ACT) && (v_cnt_q < c_V_ACT);
    ctl_raw.hs = (h_cnt_q >= c_HS_BEG) && (h_cnt_q < c_HS_END);
    ctl_raw.vs = (v_cnt_q >= c_VS_BEG) && (v_cnt_q < c_VS_END);
    ctl_raw.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // The address walks linearly through visible pixels; blanking simply holds it,
  // so the start of each line is already y*H_ACTIVE without any multiply.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == c_H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == c_V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    addr_d = addr_q;
    if ((h_cnt_d == '0) && (v_cnt_d == '0)) begin
      addr_d = '0;
    end else if (ctl_raw.de) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < c_DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      addr_q   <= addr_d;
      if (ctl_raw.fs) begin
        mode_q <= color_mode;
      end
      dly_q[0] <= ctl_raw;
      for (int i = 1; i < c_DEPTH; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Palette enable is the data-enable that travelled alongside fb_data's latency.
  if (FB_LATENCY == 0) begin : g_en_raw
    assign pal_en = ctl_raw.de;
  end else begin : g_en_dly
    assign pal_en = dly_q[FB_LATENCY-1].de;
  end

  palette_lut u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pal_en),
    .id_i    (fb_data),
    .mode_i  (mode_q),
    .red_o   (red),
    .green_o (green),
    .blue_o  (blue)
  );

  assign fb_addr     = addr_q;
  assign de          = dly_q[c_DEPTH-1].de;
  assign hsync       = dly_q[c_DEPTH-1].hs;
  assign vsync       = dly_q[c_DEPTH-1].vs;
  assign frame_start = dly_q[c_DEPTH-1].fs;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// +------------------------------------------------------------------+
// | tb_fb_scanout : scoreboard bench on a shrunken raster timing      |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fb_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int LAT = 2, PIPE = LAT + 1;
  localparam int FRAME = HT * VT;

  typedef struct {
    bit de, hs, vs, fs;
    int id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        color_mode = 1'b0;
  logic [19:0] fb_addr;
  logic [5:0]  fb_data;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [19:0] a1, a2;

  int n_vec = 0;
  int n_err = 0;

  exp_t q[$];
  int   mh = 0, mv = 0;
  bit   mode_ref = 1'b0;
  bit   sb_on = 1'b0;

  function automatic logic [5:0] id_of(input logic [19:0] a);
    return (a == 20'd0) ? 6'd10 : a[5:0];
  endfunction

  function automatic int exp_addr(input int h, input int v);
    if (v >= VA) return VA * HA;
    return (h < HA) ? v * HA + h : (v + 1) * HA;
  endfunction

  function automatic logic [23:0] pal_rgb(input int id, input bit m);
    int i;
    i = (id <= 23) ? id * 11 : 255;
    if (m) return {8'(i / 2), 8'(i - i / 4), 8'(i)};
    return {8'(i), 8'(i), 8'(i)};
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1 <= fb_addr;
    a2 <= a1;
  end
  assign fb_data = id_of(a2);

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color_mode(color_mode),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  // Scoreboard: expected control/pixel pushed per raster position, popped PIPE cycles later.
  always begin : sb
    bit r, cm;
    exp_t e, cur;
    logic [23:0] er;
    int ea;
    @(posedge clk);
    r  = rst_n;
    cm = color_mode;
    #2;
    if (!r) begin
      q.delete();
      mode_ref = 1'b0;
      mh = 0;
      mv = 0;
      sb_on = 1'b1;
    end else begin
      if (mh == 0 && mv == 0) mode_ref = cm;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    if (sb_on) begin
      ea = exp_addr(mh, mv);
      n_vec++;
      if (fb_addr !== 20'(ea)) begin
        n_err++;
        $display("FAIL sb_addr t=%0t pos=(%0d,%0d) got %0d exp %0d", $time, mh, mv, fb_addr, ea);
      end
      if (q.size() == PIPE) e = q.pop_front();
      else e = '{de: 0, hs: 0, vs: 0, fs: 0, id: 0};
      er = e.de ? pal_rgb(e.id, mode_ref) : 24'h0;
      n_vec++;
      if ({de, hsync, vsync, frame_start} !== {e.de, e.hs, e.vs, e.fs}) begin
        n_err++;
        $display("FAIL sb_ctl t=%0t got de/hs/vs/fs=%b%b%b%b exp %b%b%b%b", $time,
                 de, hsync, vsync, frame_start, e.de, e.hs, e.vs, e.fs);
      end
      n_vec++;
      if ({red, green, blue} !== er) begin
        n_err++;
        $display("FAIL sb_rgb t=%0t got %h exp %h", $time, {red, green, blue}, er);
      end
      cur.de = (mh < HA) && (mv < VA);
      cur.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
      cur.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
      cur.fs = (mh == 0) && (mv == 0);
      cur.id = int'(id_of(20'(ea)));
      q.push_back(cur);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int k = 0; k < FRAME + 20; k++) begin
      tick(1);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_fs timeout got no frame_start exp pulse");
    end
  endtask

  task automatic test_reset();
    tick(4);
    n_vec++;
    if ({de, hsync, vsync, frame_start} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b exp 0000", {de, hsync, vsync, frame_start});
    end
    n_vec++;
    if ({red, green, blue} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_rgb got %h exp 000000", {red, green, blue});
    end
    n_vec++;
    if (fb_addr !== 20'd0) begin
      n_err++;
      $display("FAIL reset_addr got %0d exp 0", fb_addr);
    end
  endtask

  task automatic test_frame();
    int dec = 0, vcnt = 0, vfirst = -1, hlast = -1, hrise = 0, hbad = 0;
    bit hprev = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_fs();
    for (int i = 0; i < FRAME; i++) begin
      if (de === 1'b1) dec++;
      if (vsync === 1'b1) begin
        vcnt++;
        if (vfirst < 0) vfirst = i;
      end
      if (hsync === 1'b1 && !hprev) begin
        if (hlast >= 0 && i - hlast != HT) hbad++;
        hlast = i;
        hrise++;
      end
      hprev = (hsync === 1'b1);
      tick(1);
    end
    n_vec++;
    if (dec != HA * VA) begin n_err++; $display("FAIL frame_de_count got %0d exp %0d", dec, HA * VA); end
    n_vec++;
    if (vcnt != VS * HT) begin n_err++; $display("FAIL frame_vs_len got %0d exp %0d", vcnt, VS * HT); end
    n_vec++;
    if (vfirst != (VA + VF) * HT) begin n_err++; $display("FAIL frame_vs_start got %0d exp %0d", vfirst, (VA + VF) * HT); end
    n_vec++;
    if (hrise != VT || hbad != 0) begin
      n_err++;
      $display("FAIL frame_hs_period got rises=%0d bad=%0d exp rises=%0d bad=0", hrise, hbad, VT);
    end
    n_vec++;
    if (frame_start !== 1'b1) begin n_err++; $display("FAIL frame_period got fs=%b exp 1", frame_start); end
  endtask

  task automatic test_grey_palette();
    n_vec++;
    if ({red, green, blue} !== {8'd110, 8'd110, 8'd110}) begin
      n_err++; $display("FAIL grey_id10 got %h exp 6e6e6e", {red, green, blue});
    end
    tick(HT + 7);
    n_vec++;
    if ({red, green, blue} !== {8'd253, 8'd253, 8'd253}) begin
      n_err++; $display("FAIL grey_id23 got %h exp fdfdfd", {red, green, blue});
    end
    tick(HT + 1);
    n_vec++;
    if ({red, green, blue} !== {8'd255, 8'd255, 8'd255}) begin
      n_err++; $display("FAIL grey_id40 got %h exp ffffff", {red, green, blue});
    end
  endtask

  task automatic test_blue_mode();
    @(negedge clk) color_mode = 1'b1;
    wait_fs();
    n_vec++;
    if ({red, green, blue} !== {8'd55, 8'd83, 8'd110}) begin
      n_err++; $display("FAIL blue_id10 got %h exp 37536e", {red, green, blue});
    end
    tick(HT + 4);
    n_vec++;
    if ({red, green, blue} !== {8'd110, 8'd165, 8'd220}) begin
      n_err++; $display("FAIL blue_id20 got %h exp 6ea5dc", {red, green, blue});
    end
  endtask

  task automatic test_mode_toggle();
    tick(3 * HT - (HT + 4));
    @(negedge clk) color_mode = 1'b0;
    tick(5 * HT + 4 - 3 * HT);
    n_vec++;
    if ({red, green, blue} !== {8'd110, 8'd165, 8'd220}) begin
      n_err++; $display("FAIL toggle_hold got %h exp 6ea5dc", {red, green, blue});
    end
    wait_fs();
    tick(HT + 4);
    n_vec++;
    if ({red, green, blue} !== {8'd220, 8'd220, 8'd220}) begin
      n_err++; $display("FAIL toggle_next got %h exp dcdcdc", {red, green, blue});
    end
  endtask

  task automatic test_reset_mid();
    int k;
    wait_fs();
    tick(4 * HT);
    @(negedge clk) rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_vec++;
      if ({de, hsync, vsync, frame_start, red, green, blue, fb_addr} !== 48'h0) begin
        n_err++;
        $display("FAIL midrst_zero cyc=%0d got %b%b%b%b %h addr=%0d exp all 0", i,
                 de, hsync, vsync, frame_start, {red, green, blue}, fb_addr);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    n_vec++;
    if (fb_addr !== 20'd0) begin n_err++; $display("FAIL midrst_addr got %0d exp 0", fb_addr); end
    for (k = 1; k <= 8; k++) begin
      tick(1);
      if (de === 1'b1) break;
    end
    n_vec++;
    if (k != PIPE || frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_de_rise got k=%0d fs=%b exp k=%0d fs=1", k, frame_start, PIPE);
    end
  endtask

  task automatic test_two_frames();
    int nfs = 0;
    wait_fs();
    tick((VA - 1) * HT + (HA - 1) - PIPE);
    n_vec++;
    if (fb_addr !== 20'(HA * VA - 1)) begin
      n_err++; $display("FAIL last_pix_addr got %0d exp %0d", fb_addr, HA * VA - 1);
    end
    tick(FRAME - 1 - PIPE - ((VA - 1) * HT + (HA - 1) - PIPE));
    n_vec++;
    if (fb_addr !== 20'(HA * VA)) begin
      n_err++; $display("FAIL blank_hold_addr got %0d exp %0d", fb_addr, HA * VA);
    end
    tick(1);
    n_vec++;
    if (fb_addr !== 20'd0) begin n_err++; $display("FAIL wrap_addr got %0d exp 0", fb_addr); end
    tick(PIPE);
    n_vec++;
    if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_period got %b exp 1", frame_start); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1);
      if (frame_start === 1'b1) nfs++;
    end
    n_vec++;
    if (nfs != 2) begin n_err++; $display("FAIL fs_count got %0d exp 2", nfs); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_grey_palette();
    test_blue_mode();
    test_mode_toggle();
    test_reset_mid();
    test_two_frames();
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
